// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the Tx frame arbiter.
//   state_e        : arbiter FSM states
//   CNT_W          : beat counter width
//   onehot_to_idx  : one-hot (up to 8 bits) to binary index
package tx_arb_pkg;

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Index of the set bit; 0 when no bit is set.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after last_i+1 (mod N_PORTS).
//   req_i   : request vector
//   last_i  : index of the most recent winner
//   grant_o : one-hot winner (0 when no request)
//   any_o   : at least one request present
module rr_pick #(
  parameter int unsigned N_PORTS = 4
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [2:0]         last_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic               any_o
);

  // Scan offsets 1..N so the previous winner is considered last.
  always_comb begin
    int k;
    grant_o = '0;
    any_o   = 1'b0;
    k       = 0;
    for (int i = 1; i <= int'(N_PORTS); i++) begin
      k = (int'(last_i) + i) % int'(N_PORTS);
      if (!any_o && req_i[k]) begin
        grant_o[k] = 1'b1;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Frame-locked round-robin arbiter feeding the MAC Tx AXIS input, with
// oversize-frame truncation.
//   i_txc, i_reset          : clock, synchronous active-high reset
//   s_axis_*                : N_PORTS requester streams (port k at slice k)
//   m00_axis_*              : stream to the MAC (combinational mux of owner)
//   o_grant                 : one-hot current owner, 0 when idle
//   o_trunc / o_trunc_port  : truncation pulse and port of last truncation
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned N_PORTS   = 4,
  parameter int unsigned MAX_BEATS = 190
) (
  input  logic                  i_txc,
  input  logic                  i_reset,
  input  logic [64*N_PORTS-1:0] s_axis_tdata,
  input  logic [8*N_PORTS-1:0]  s_axis_tkeep,
  input  logic [N_PORTS-1:0]    s_axis_tvalid,
  input  logic [N_PORTS-1:0]    s_axis_tlast,
  output logic [N_PORTS-1:0]    s_axis_tready,
  output logic [63:0]           m00_axis_tdata,
  output logic [7:0]            m00_axis_tkeep,
  output logic                  m00_axis_tvalid,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready,
  output logic [N_PORTS-1:0]    o_grant,
  output logic                  o_trunc,
  output logic [2:0]            o_trunc_port
);

  state_e             state_q, state_d;
  logic [N_PORTS-1:0] grant_q, grant_d;
  logic [2:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;
  logic [2:0]         trunc_port_q, trunc_port_d;

  logic [N_PORTS-1:0] pick_grant;
  logic               pick_any;

  logic [63:0]        sel_data;
  logic [7:0]         sel_keep;
  logic               sel_valid;
  logic               sel_last;

  rr_pick #(.N_PORTS(N_PORTS)) u_pick (
    .req_i   (s_axis_tvalid),
    .last_i  (last_q),
    .grant_o (pick_grant),
    .any_o   (pick_any)
  );

  // AND-OR mux of the owning port's stream.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = |(s_axis_tvalid & grant_q);
    sel_last  = |(s_axis_tlast & grant_q);
    for (int k = 0; k < int'(N_PORTS); k++) begin
      if (grant_q[k]) begin
        sel_data = sel_data | s_axis_tdata[64*k +: 64];
        sel_keep = sel_keep | s_axis_tkeep[8*k +: 8];
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    trunc_d         = 1'b0;
    trunc_port_d    = trunc_port_q;
    s_axis_tready   = '0;
    m00_axis_tdata  = '0;
    m00_axis_tkeep  = '0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          last_d  = onehot_to_idx(8'(pick_grant));
          cnt_d   = '0;
          state_d = ST_PASS;
        end
      end

      ST_PASS: begin
        m00_axis_tdata  = sel_data;
        m00_axis_tkeep  = sel_keep;
        m00_axis_tvalid = sel_valid;
        m00_axis_tlast  = sel_last;
        s_axis_tready   = grant_q & {N_PORTS{m00_axis_tready}};
        if (sel_valid && m00_axis_tready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (sel_last) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_W'(MAX_BEATS - 1)) begin
            // Cut here: close the frame for the MAC, discard the rest.
            m00_axis_tlast = 1'b1;
            trunc_d        = 1'b1;
            trunc_port_d   = onehot_to_idx(8'(grant_q));
            state_d        = ST_DROP;
          end
        end
      end

      ST_DROP: begin
        s_axis_tready = grant_q;
        if (sel_valid && sel_last) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge i_txc) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_q       <= 3'(N_PORTS - 1);
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      trunc_port_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      trunc_q      <= trunc_d;
      trunc_port_q <= trunc_port_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_trunc      = trunc_q;
  assign o_trunc_port = trunc_port_q;

endmodule
